alu_mc: RTL and testbench

- Parametrised, multi-cycle successor of the single-cycle datapath ALU.
- Width is a parameter. It adds iterative multiply and divide (signed and unsigned) with a high/low result pair.
- All results and flags are registered. Operations are issued and retired through a valid/ready handshake.
- Sits in the execute stage. The pipeline stalls on in_ready low.

---
 rtl/alu_mc_if.sv | 30 +++
 rtl/alu_mc.sv | 189 ++++++++++++++++++
 tb/tb_alu_mc.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Issue/retire bundle between the execute stage and alu_mc.
// The master drives operations in; the slave returns registered results.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       aluop;
   logic [WIDTH-1:0] porta;
   logic [WIDTH-1:0] portb;
   logic             out_valid;
   logic [WIDTH-1:0] out_lo;
   logic [WIDTH-1:0] out_hi;
   logic             zero;
   logic             neg;
   logic             overflow;
   logic             div_zero;

   modport master (
      output in_valid, aluop, porta, portb,
      input  in_ready, out_valid, out_lo, out_hi,
      input  zero, neg, overflow, div_zero
   );

   modport slave (
      input  in_valid, aluop, porta, portb,
      output in_ready, out_valid, out_lo, out_hi,
      output zero, neg, overflow, div_zero
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle ops plus iterative
// shift-add multiply and restoring divide, all outputs registered.
module alu_mc #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input logic     CLK,
   input logic     nRST,
   alu_mc_if.slave bus
);
   localparam logic [3:0] SLL = 4'd0, SRL = 4'd1, ADD = 4'd2;
   localparam logic [3:0] SUB = 4'd3, AND = 4'd4, OR = 4'd5;
   localparam logic [3:0] XOR = 4'd6, NOR = 4'd7, SLT = 4'd8;
   localparam logic [3:0] SLTU = 4'd9, MULU = 4'd10, MUL = 4'd11;
   localparam logic [3:0] DIVU = 4'd12, DIV = 4'd13;
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t           state, state_nx;
   logic [SHW-1:0]   cnt;
   logic             op_div, op_sgn, sa, sb;
   logic [WIDTH-1:0] a_q, acc, sh, opb;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic             v_q, z_q, n_q, o_q, d_q;

   logic             accept, is_mc, sgn_in;
   logic [WIDTH-1:0] a, b, sum, dif, sc_r;
   logic             sc_o;
   logic [WIDTH:0]   mul_sum, div_t;
   logic [2*WIDTH-1:0] prod, prod_f;
   logic [WIDTH-1:0] fx_lo, fx_hi;
   logic             fx_o, fx_d;

   assign a      = bus.porta;
   assign b      = bus.portb;
   assign accept = bus.in_valid && bus.in_ready;
   assign is_mc  = (bus.aluop >= MULU) && (bus.aluop <= DIV);
   assign sgn_in = (bus.aluop == MUL) || (bus.aluop == DIV);

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = v_q;
   assign bus.out_lo    = lo_q;
   assign bus.out_hi    = hi_q;
   assign bus.zero      = z_q;
   assign bus.neg       = n_q;
   assign bus.overflow  = o_q;
   assign bus.div_zero  = d_q;

   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept && is_mc) state_nx = ITER;
         ITER:    if (cnt == LAST) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sum  = a + b;
      dif  = a - b;
      sc_r = '0;
      sc_o = 1'b0;
      unique case (1'b1)
         (bus.aluop == SLL):  sc_r = b << a[SHW-1:0];
         (bus.aluop == SRL):  sc_r = b >> a[SHW-1:0];
         (bus.aluop == ADD): begin
            sc_r = sum;
            sc_o = (a[WIDTH-1] == b[WIDTH-1]) &&
                   (sum[WIDTH-1] != a[WIDTH-1]);
         end
         (bus.aluop == SUB): begin
            sc_r = dif;
            sc_o = (a[WIDTH-1] != b[WIDTH-1]) &&
                   (dif[WIDTH-1] != a[WIDTH-1]);
         end
         (bus.aluop == AND):  sc_r = a & b;
         (bus.aluop == OR):   sc_r = a | b;
         (bus.aluop == XOR):  sc_r = a ^ b;
         (bus.aluop == NOR):  sc_r = ~(a | b);
         (bus.aluop == SLT):
            sc_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         (bus.aluop == SLTU): sc_r = {{(WIDTH-1){1'b0}}, a < b};
         default:             sc_r = '0;
      endcase
   end

   // acc is the product high half / partial remainder, sh the
   // multiplier being consumed / dividend shifting into quotient
   assign mul_sum = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
   assign div_t   = {acc, sh[WIDTH-1]} - {1'b0, opb};

   always_comb begin
      prod   = {acc, sh};
      prod_f = (sa ^ sb) ? -prod : prod;
      fx_lo  = prod_f[WIDTH-1:0];
      fx_hi  = prod_f[2*WIDTH-1:WIDTH];
      fx_o   = 1'b0;
      fx_d   = 1'b0;
      if (op_div) begin
         if (opb == '0) begin
            fx_lo = '1;
            fx_hi = a_q;
            fx_d  = 1'b1;
         end else begin
            fx_lo = (sa ^ sb) ? -sh : sh;
            fx_hi = sa ? -acc : acc;
            fx_o  = op_sgn && (a_q == MIN) && sb && (opb == ONE);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cnt    <= '0;
         op_div <= 1'b0;
         op_sgn <= 1'b0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         a_q    <= '0;
         acc    <= '0;
         sh     <= '0;
         opb    <= '0;
         lo_q   <= '0;
         hi_q   <= '0;
         v_q    <= 1'b0;
         z_q    <= 1'b1;
         n_q    <= 1'b0;
         o_q    <= 1'b0;
         d_q    <= 1'b0;
      end else begin
         v_q <= 1'b0;
         unique case (state)
            IDLE: if (accept) begin
               if (is_mc) begin
                  op_div <= bus.aluop[2];
                  op_sgn <= sgn_in;
                  sa     <= sgn_in & a[WIDTH-1];
                  sb     <= sgn_in & b[WIDTH-1];
                  a_q    <= a;
                  sh     <= (sgn_in & a[WIDTH-1]) ? -a : a;
                  opb    <= (sgn_in & b[WIDTH-1]) ? -b : b;
                  acc    <= '0;
                  cnt    <= '0;
               end else begin
                  lo_q <= sc_r;
                  hi_q <= '0;
                  z_q  <= (sc_r == '0);
                  n_q  <= sc_r[WIDTH-1];
                  o_q  <= sc_o;
                  d_q  <= 1'b0;
                  v_q  <= 1'b1;
               end
            end
            ITER: begin
               cnt <= cnt + 1'b1;
               if (!op_div) begin
                  acc <= mul_sum[WIDTH:1];
                  sh  <= {mul_sum[0], sh[WIDTH-1:1]};
               end else if (!div_t[WIDTH]) begin
                  acc <= div_t[WIDTH-1:0];
                  sh  <= {sh[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= {acc[WIDTH-2:0], sh[WIDTH-1]};
                  sh  <= {sh[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               lo_q <= fx_lo;
               hi_q <= fx_hi;
               z_q  <= (fx_lo == '0);
               n_q  <= fx_lo[WIDTH-1];
               o_q  <= fx_o;
               d_q  <= fx_d;
               v_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit and an 8-bit instance
// driven from hand-computed vectors.
module tb_alu_mc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   alu_mc_if #(.WIDTH(32)) b32 ();
   alu_mc_if #(.WIDTH(8))  b8 ();

   alu_mc #(.WIDTH(32)) u32 (
      .CLK (clk), .nRST(rst_n), .bus(b32.slave)
   );
   alu_mc #(.WIDTH(8)) u8 (
      .CLK (clk), .nRST(rst_n), .bus(b8.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic sc_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      b32.in_valid = 1'b1;
      b32.aluop    = op;
      b32.porta    = a;
      b32.portb    = b;
      @(negedge clk);
   endtask

   task automatic mc_op(input string tag,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      int n;
      @(negedge clk);
      check({tag, "_rdy"}, 64'(b32.in_ready), 64'd1);
      b32.in_valid = 1'b1;
      b32.aluop    = op;
      b32.porta    = a;
      b32.portb    = b;
      @(negedge clk);
      n = 1;
      check({tag, "_busy"}, 64'(b32.in_ready), 64'd0);
      b32.aluop = 4'd2;
      b32.porta = 32'h1234;
      b32.portb = 32'h1;
      while (!b32.out_valid && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 5) b32.in_valid = 1'b0;
      end
      b32.in_valid = 1'b0;
      check({tag, "_lat"}, 64'(n), 64'd34);
      check({tag, "_rdy2"}, 64'(b32.in_ready), 64'd1);
   endtask

   task automatic res32(input string tag,
                        input logic [31:0] lo,
                        input logic [31:0] hi,
                        input logic [3:0] f);
      check({tag, "_v"}, 64'(b32.out_valid), 64'd1);
      check({tag, "_lo"}, 64'(b32.out_lo), 64'(lo));
      check({tag, "_hi"}, 64'(b32.out_hi), 64'(hi));
      check({tag, "_flg"},
            64'({b32.zero, b32.neg, b32.overflow, b32.div_zero}),
            64'(f));
   endtask

   initial begin
      int n;
      int pulses;
      b32.in_valid = 1'b0;
      b32.aluop    = '0;
      b32.porta    = '0;
      b32.portb    = '0;
      b8.in_valid  = 1'b0;
      b8.aluop     = '0;
      b8.porta     = '0;
      b8.portb     = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_rdy", 64'(b32.in_ready), 64'd1);
      check("rst_v", 64'(b32.out_valid), 64'd0);
      check("rst_lo", 64'(b32.out_lo), 64'd0);
      check("rst_hi", 64'(b32.out_hi), 64'd0);
      check("rst_flg",
            64'({b32.zero, b32.neg, b32.overflow, b32.div_zero}),
            64'b1000);

      sc_op(4'd11, 32'hFFFFFFFD, 32'd7);
      b32.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_rdy", 64'(b32.in_ready), 64'd1);
      check("abort_lo", 64'(b32.out_lo), 64'd0);
      check("abort_z", 64'(b32.zero), 64'd1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (b32.out_valid) pulses++;
         @(negedge clk);
      end
      check("abort_pulse", 64'(pulses), 64'd0);

      sc_op(4'd2, 32'h7FFFFFFF, 32'd1);
      res32("add", 32'h80000000, 0, 4'b0110);
      sc_op(4'd3, 32'h80000000, 32'd1);
      res32("sub", 32'h7FFFFFFF, 0, 4'b0010);
      sc_op(4'd8, 32'hFFFFFFFF, 32'd1);
      res32("slt", 32'd1, 0, 4'b0000);
      b32.in_valid = 1'b0;
      @(negedge clk);
      check("b2b_end", 64'(b32.out_valid), 64'd0);

      sc_op(4'd9, 32'hFFFFFFFF, 32'd1);
      res32("sltu", 32'd0, 0, 4'b1000);
      sc_op(4'd1, 32'd31, 32'h80000000);
      res32("srl", 32'd1, 0, 4'b0000);
      sc_op(4'd7, 32'd0, 32'd0);
      res32("nor", 32'hFFFFFFFF, 0, 4'b0100);
      sc_op(4'd14, 32'h55, 32'h66);
      res32("rsv", 32'd0, 0, 4'b1000);
      b32.in_valid = 1'b0;

      mc_op("mul", 4'd11, 32'hFFFFFFFD, 32'd7);
      res32("mul", 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b0100);
      @(negedge clk);
      check("mul_once", 64'(b32.out_valid), 64'd0);
      check("mul_hold", 64'(b32.out_lo), 64'hFFFFFFEB);

      mc_op("mulu", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
      res32("mulu", 32'd1, 32'hFFFFFFFE, 4'b0000);
      mc_op("div", 4'd13, 32'hFFFFFFF9, 32'd2);
      res32("div", 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0100);
      mc_op("divu", 4'd12, 32'd100, 32'd7);
      res32("divu", 32'd14, 32'd2, 4'b0000);
      mc_op("dz", 4'd12, 32'd5, 32'd0);
      res32("dz", 32'hFFFFFFFF, 32'd5, 4'b0101);
      mc_op("dovf", 4'd13, 32'h80000000, 32'hFFFFFFFF);
      res32("dovf", 32'h80000000, 32'd0, 4'b0110);

      @(negedge clk);
      b8.in_valid = 1'b1;
      b8.aluop    = 4'd0;
      b8.porta    = 8'h0B;
      b8.portb    = 8'h01;
      @(negedge clk);
      check("w8_sll_v", 64'(b8.out_valid), 64'd1);
      check("w8_sll", 64'(b8.out_lo), 64'h08);
      b8.aluop = 4'd10;
      b8.porta = 8'hFF;
      b8.portb = 8'hFF;
      @(negedge clk);
      b8.in_valid = 1'b0;
      n = 1;
      while (!b8.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("w8_lat", 64'(n), 64'd10);
      check("w8_lo", 64'(b8.out_lo), 64'h01);
      check("w8_hi", 64'(b8.out_hi), 64'hFE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
